// File: rtl/mc_ctrl.sv
//-----------------------------------------------------------------------------
// Module      : mc_ctrl
// Description : Multi-cycle MIPS main controller. Sequences one instruction
//               through fetch/decode/exec/mem/writeback and drives every
//               datapath enable and mux select from the current state.
// Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic [1:0] NPCSel,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       mem_we,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB_ALU = 3'd4;
    localparam logic [2:0] c_WB_MEM = 3'd5;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_NOP   = 6'b000000;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic w_is_rtype, w_is_addu, w_is_subu, w_is_jr, w_is_nop;
    logic w_is_j, w_is_jal, w_is_beq, w_is_ori, w_is_lui, w_is_lw, w_is_sw;
    logic w_is_exec;
    logic [2:0] w_alu_op;
    logic       w_alu_src;
    logic [1:0] w_ext_op;

    assign w_is_rtype = (opcode == c_OP_RTYPE);
    assign w_is_addu  = w_is_rtype && (funct == c_FN_ADDU);
    assign w_is_subu  = w_is_rtype && (funct == c_FN_SUBU);
    assign w_is_jr    = w_is_rtype && (funct == c_FN_JR);
    assign w_is_nop   = w_is_rtype && (funct == c_FN_NOP);
    assign w_is_j     = (opcode == c_OP_J);
    assign w_is_jal   = (opcode == c_OP_JAL);
    assign w_is_beq   = (opcode == c_OP_BEQ);
    assign w_is_ori   = (opcode == c_OP_ORI);
    assign w_is_lui   = (opcode == c_OP_LUI);
    assign w_is_lw    = (opcode == c_OP_LW);
    assign w_is_sw    = (opcode == c_OP_SW);
    assign w_is_exec  = w_is_addu | w_is_subu | w_is_ori | w_is_lui |
                        w_is_lw | w_is_sw | w_is_beq;

    // ALU controls depend only on the instruction, so the same values can be
    // re-driven in MEM/WB to keep the ALU result and address stable.
    assign w_alu_op  = (w_is_subu || w_is_beq) ? 3'b001 :
                       w_is_ori                ? 3'b010 :
                       w_is_lui                ? 3'b011 : 3'b000;
    assign w_alu_src = w_is_ori | w_is_lui | w_is_lw | w_is_sw;
    assign w_ext_op  = w_is_lui                          ? 2'b10 :
                       (w_is_lw || w_is_sw || w_is_beq)  ? 2'b01 : 2'b00;

    assign state = reset ? 3'd0 : r_state;

    always_comb begin
        pc_we        = 1'b0;
        NPCSel       = 2'b00;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 2'b00;
        wd_sel       = 2'b00;
        alu_src      = 1'b0;
        alu_op       = 3'b000;
        ext_op       = 2'b00;
        mem_we       = 1'b0;
        illegal      = 1'b0;
        w_next_state = c_FETCH;
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    ir_we        = 1'b1;
                    w_next_state = c_DECODE;
                end
                c_DECODE: begin
                    if (w_is_j || w_is_jal) begin
                        pc_we  = 1'b1;
                        NPCSel = 2'b10;
                        if (w_is_jal) begin
                            reg_we  = 1'b1;
                            reg_dst = 2'b10;
                            wd_sel  = 2'b10;
                        end
                    end else if (w_is_jr) begin
                        pc_we  = 1'b1;
                        NPCSel = 2'b01;
                    end else if (w_is_nop) begin
                        pc_we = 1'b1;
                    end else if (w_is_exec) begin
                        w_next_state = c_EXEC;
                    end else begin
                        // Unsupported: retire as a no-op and flag it.
                        pc_we   = 1'b1;
                        illegal = 1'b1;
                    end
                end
                c_EXEC: begin
                    if (w_is_exec) begin
                        alu_op  = w_alu_op;
                        alu_src = w_alu_src;
                        ext_op  = w_ext_op;
                        if (w_is_beq) begin
                            pc_we  = 1'b1;
                            NPCSel = zero ? 2'b11 : 2'b00;
                        end else if (w_is_lw || w_is_sw) begin
                            w_next_state = c_MEM;
                        end else begin
                            w_next_state = c_WB_ALU;
                        end
                    end
                end
                c_MEM: begin
                    if (w_is_lw || w_is_sw) begin
                        alu_op  = w_alu_op;
                        alu_src = w_alu_src;
                        ext_op  = w_ext_op;
                    end
                    if (w_is_sw) begin
                        mem_we = 1'b1;
                        pc_we  = 1'b1;
                    end else if (w_is_lw) begin
                        w_next_state = c_WB_MEM;
                    end
                end
                c_WB_ALU: begin
                    alu_op  = w_alu_op;
                    alu_src = w_alu_src;
                    ext_op  = w_ext_op;
                    reg_we  = 1'b1;
                    reg_dst = w_is_rtype ? 2'b01 : 2'b00;
                    pc_we   = 1'b1;
                end
                c_WB_MEM: begin
                    alu_op  = w_alu_op;
                    alu_src = w_alu_src;
                    ext_op  = w_ext_op;
                    reg_we  = 1'b1;
                    wd_sel  = 2'b01;
                    pc_we   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
//-----------------------------------------------------------------------------
// Module      : tb_mc_ctrl
// Description : Directed scoreboard bench for mc_ctrl; hand-computed per-cycle
//               output vectors are queued by the driver and checked by a monitor.
// Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_we, ir_we, reg_we, alu_src, mem_we, illegal;
    logic [1:0] NPCSel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op, state;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];
    string       name_q[$];

    mc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .funct   (funct),
        .zero    (zero),
        .pc_we   (pc_we),
        .NPCSel  (NPCSel),
        .ir_we   (ir_we),
        .reg_we  (reg_we),
        .reg_dst (reg_dst),
        .wd_sel  (wd_sel),
        .alu_src (alu_src),
        .alu_op  (alu_op),
        .ext_op  (ext_op),
        .mem_we  (mem_we),
        .illegal (illegal),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Packing: state, pc_we, NPCSel, ir_we, reg_we, reg_dst, wd_sel,
    //          alu_src, alu_op, ext_op, mem_we, illegal
    function automatic logic [19:0] ev(input logic [2:0] st, input logic pcw,
            input logic [1:0] npc, input logic irw, input logic rw,
            input logic [1:0] rd, input logic [1:0] wd, input logic as,
            input logic [2:0] ao, input logic [1:0] eo, input logic mw,
            input logic il);
        return {st, pcw, npc, irw, rw, rd, wd, as, ao, eo, mw, il};
    endfunction

    task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic [19:0] e);
        @(posedge clk);
        #1;
        reset  = rst;
        opcode = op;
        funct  = fn;
        zero   = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            logic [19:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, pc_we, NPCSel, ir_we, reg_we, reg_dst, wd_sel,
                  alu_src, alu_op, ext_op, mem_we, illegal};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b", nm, a, e);
            end
        end
    end

    initial begin
        // reset, then abort an sw in MEM with a 2-cycle reset
        cyc("rst_init",   1, OP_SW, 6'd0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_fetch",   0, OP_SW, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("sw_decode",  0, OP_SW, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_exec",    0, OP_SW, 6'd0, 0, ev(2,0,0,0,0,0,0,1,0,1,0,0));
        cyc("rst_in_mem", 1, OP_SW, 6'd0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0));
        cyc("rst_2nd",    1, OP_SW, 6'd0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0));
        // addu
        cyc("addu_fetch", 0, OP_R, 6'b100001, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("addu_dec",   0, OP_R, 6'b100001, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_exec",  0, OP_R, 6'b100001, 0, ev(2,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_wb",    0, OP_R, 6'b100001, 0, ev(4,1,0,0,1,1,0,0,0,0,0,0));
        // lw
        cyc("lw_fetch",   0, OP_LW, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("lw_dec",     0, OP_LW, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_exec",    0, OP_LW, 6'd0, 0, ev(2,0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw_mem",     0, OP_LW, 6'd0, 0, ev(3,0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw_wbmem",   0, OP_LW, 6'd0, 0, ev(5,1,0,0,1,0,1,1,0,1,0,0));
        // sw
        cyc("sw2_fetch",  0, OP_SW, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("sw2_dec",    0, OP_SW, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw2_exec",   0, OP_SW, 6'd0, 0, ev(2,0,0,0,0,0,0,1,0,1,0,0));
        cyc("sw2_mem",    0, OP_SW, 6'd0, 0, ev(3,1,0,0,0,0,0,1,0,1,1,0));
        // beq taken / not taken
        cyc("beqt_fetch", 0, OP_BEQ, 6'd0, 1, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("beqt_dec",   0, OP_BEQ, 6'd0, 1, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("beqt_exec",  0, OP_BEQ, 6'd0, 1, ev(2,1,3,0,0,0,0,0,1,1,0,0));
        cyc("beqn_fetch", 0, OP_BEQ, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("beqn_dec",   0, OP_BEQ, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("beqn_exec",  0, OP_BEQ, 6'd0, 0, ev(2,1,0,0,0,0,0,0,1,1,0,0));
        // jumps
        cyc("jal_fetch",  0, OP_JAL, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("jal_dec",    0, OP_JAL, 6'd0, 0, ev(1,1,2,0,1,2,2,0,0,0,0,0));
        cyc("jr_fetch",   0, OP_R, 6'b001000, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("jr_dec",     0, OP_R, 6'b001000, 0, ev(1,1,1,0,0,0,0,0,0,0,0,0));
        cyc("bad_fetch",  0, OP_BAD, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("bad_dec",    0, OP_BAD, 6'd0, 0, ev(1,1,0,0,0,0,0,0,0,0,0,1));
        cyc("j_fetch",    0, OP_J, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("j_dec",      0, OP_J, 6'd0, 0, ev(1,1,2,0,0,0,0,0,0,0,0,0));
        // immediates
        cyc("ori_fetch",  0, OP_ORI, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("ori_dec",    0, OP_ORI, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("ori_exec",   0, OP_ORI, 6'd0, 0, ev(2,0,0,0,0,0,0,1,2,0,0,0));
        cyc("ori_wb",     0, OP_ORI, 6'd0, 0, ev(4,1,0,0,1,0,0,1,2,0,0,0));
        cyc("lui_fetch",  0, OP_LUI, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("lui_dec",    0, OP_LUI, 6'd0, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_exec",   0, OP_LUI, 6'd0, 0, ev(2,0,0,0,0,0,0,1,3,2,0,0));
        cyc("lui_wb",     0, OP_LUI, 6'd0, 0, ev(4,1,0,0,1,0,0,1,3,2,0,0));
        // subu, bad funct, nop
        cyc("subu_fetch", 0, OP_R, 6'b100011, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("subu_dec",   0, OP_R, 6'b100011, 0, ev(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("subu_exec",  0, OP_R, 6'b100011, 0, ev(2,0,0,0,0,0,0,0,1,0,0,0));
        cyc("subu_wb",    0, OP_R, 6'b100011, 0, ev(4,1,0,0,1,1,0,0,1,0,0,0));
        cyc("badfn_fetch",0, OP_R, 6'b111111, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("badfn_dec",  0, OP_R, 6'b111111, 0, ev(1,1,0,0,0,0,0,0,0,0,0,1));
        cyc("nop_fetch",  0, OP_R, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        cyc("nop_dec",    0, OP_R, 6'd0, 0, ev(1,1,0,0,0,0,0,0,0,0,0,0));
        cyc("end_fetch",  0, OP_R, 6'd0, 0, ev(0,0,0,1,0,0,0,0,0,0,0,0));
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
